// File: rtl/camera_fake_pattern_gen_if.sv
// Video bus of the fake camera: OV-style line/frame strobes and 8-bit pixel data.
interface camera_fake_pattern_gen_if;
    logic       href;
    logic       hsync;
    logic       vsync;
    logic [7:0] camData;

    modport master (output href, hsync, vsync, camData);
    modport slave  (input  href, hsync, vsync, camData);
endinterface

// File: rtl/camera_fake_pattern_gen.sv
// Parametrised fake camera: OV-style timing with black / grid / x-ramp / bouncing-blob patterns.
// Optional low-level background noise from a 16-bit LFSR when CAMFAKE_NOISE_EN is defined.
module camera_fake_pattern_gen #(
    parameter int PCLK_PER_PIXEL = 1,
    parameter int WIDTH          = 1280,
    parameter int H_FRONT_PORCH  = 19,
    parameter int H_SYNC_PULSE   = 80,
    parameter int H_BACK_PORCH   = 45,
    parameter int HEIGHT         = 800,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 3,
    parameter int V_BACK_PORCH   = 17,
    parameter int NUM_BLOBS      = 4,
    parameter int BLOB_SIZE      = 60,
    parameter int STEP           = 4,
    parameter int GRID_PITCH     = 120
) (
    input  logic                             pclk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [1:0]                       mode,
    camera_fake_pattern_gen_if.master        cam,
    output logic                             frame_done,
    output logic [15:0]                      frame_count
);
    localparam int LINE_TOTAL  = (WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH) * PCLK_PER_PIXEL;
    localparam int FRAME_LINES = HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam logic [15:0] LINE_LAST    = 16'(LINE_TOTAL - 1);
    localparam logic [15:0] FRAME_LAST   = 16'(FRAME_LINES - 1);
    localparam logic [15:0] SUB_LAST     = 16'(PCLK_PER_PIXEL - 1);
    localparam logic [15:0] ACTIVE_CYC   = 16'(WIDTH * PCLK_PER_PIXEL);
    localparam logic [15:0] ACTIVE_LINES = 16'(HEIGHT);
    localparam logic [15:0] HS_START     = 16'(WIDTH + H_FRONT_PORCH);
    localparam logic [15:0] HS_END       = 16'(WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [15:0] VS_START     = 16'(HEIGHT + V_FRONT_PORCH);
    localparam logic [15:0] VS_END       = 16'(HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [15:0] GRID_LAST    = 16'(GRID_PITCH - 1);
    localparam logic [15:0] GRID_HALF    = 16'(GRID_PITCH / 2);
    localparam logic [15:0] BLOB_W       = 16'(BLOB_SIZE);
    localparam logic [15:0] STEP_W       = 16'(STEP);
    localparam logic [15:0] X_MAX        = 16'(WIDTH - BLOB_SIZE);
    localparam logic [15:0] Y_MAX        = 16'(HEIGHT - BLOB_SIZE);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [1:0]  mode_q;
    logic [15:0] cx, cy, sub, px, gx, gy;
    logic [15:0] blob_x [NUM_BLOBS];
    logic [15:0] blob_y [NUM_BLOBS];
    logic        blob_dx [NUM_BLOBS];
    logic        blob_dy [NUM_BLOBS];

    logic        line_end, frame_end, pix_end, active, in_blob;
    logic [7:0]  pix;

    assign line_end  = (cx == LINE_LAST);
    assign frame_end = line_end && (cy == FRAME_LAST);
    assign pix_end   = (sub == SUB_LAST);
    assign active    = (cy < ACTIVE_LINES) && (cx < ACTIVE_CYC);

`ifdef CAMFAKE_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (state == RUN)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
`endif

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        in_blob = 1'b0;
        for (int k = 0; k < NUM_BLOBS; k++) begin
            if (px >= blob_x[k] && px < blob_x[k] + BLOB_W &&
                cy >= blob_y[k] && cy < blob_y[k] + BLOB_W)
                in_blob = 1'b1;
        end
    end

    always_comb begin
        pix = 8'h00;
        case (mode_q)
            2'd1:    pix = (gx < GRID_HALF && gy < GRID_HALF) ? 8'hFF : 8'h00;
            2'd2:    pix = px[7:0];
            2'd3:    pix = in_blob ? 8'hFF : 8'h00;
            default: pix = 8'h00;
        endcase
`ifdef CAMFAKE_NOISE_EN
        if (pix == 8'h00)
            pix = {4'h0, lfsr[3:0]};
`endif
    end

    // Raster counters; they only leave RUN at a frame wrap, so IDLE always holds them at zero.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            cx     <= '0;
            cy     <= '0;
            sub    <= '0;
            px     <= '0;
            gx     <= '0;
            gy     <= '0;
        end else if (state == IDLE) begin
            if (en) begin
                state  <= RUN;
                mode_q <= mode;
            end
        end else begin
            cx  <= line_end ? '0 : cx + 16'd1;
            sub <= (pix_end || line_end) ? '0 : sub + 16'd1;
            if (line_end) begin
                px <= '0;
                gx <= '0;
                cy <= frame_end ? '0 : cy + 16'd1;
                gy <= (frame_end || gy == GRID_LAST) ? '0 : gy + 16'd1;
            end else if (pix_end) begin
                px <= px + 16'd1;
                gx <= (gx == GRID_LAST) ? '0 : gx + 16'd1;
            end
            if (frame_end) begin
                if (en)
                    mode_q <= mode;
                else
                    state <= IDLE;
            end
        end
    end

    // NOTE: blob positions are architectural state, so the whole array is reset, not just a pointer.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_BLOBS; k++) begin
                blob_x[k]  <= 16'(k * (WIDTH / NUM_BLOBS));
                blob_y[k]  <= 16'((k * BLOB_SIZE) % (HEIGHT - BLOB_SIZE));
                blob_dx[k] <= ((k % 2) == 0);
                blob_dy[k] <= 1'b1;
            end
        end else if (state == RUN && frame_end && mode_q == 2'd3) begin
            for (int k = 0; k < NUM_BLOBS; k++) begin
                if (blob_dx[k]) begin
                    if (blob_x[k] + STEP_W > X_MAX) begin
                        blob_x[k]  <= X_MAX;
                        blob_dx[k] <= 1'b0;
                    end else
                        blob_x[k] <= blob_x[k] + STEP_W;
                end else if (blob_x[k] < STEP_W) begin
                    blob_x[k]  <= '0;
                    blob_dx[k] <= 1'b1;
                end else
                    blob_x[k] <= blob_x[k] - STEP_W;

                if (blob_dy[k]) begin
                    if (blob_y[k] + STEP_W > Y_MAX) begin
                        blob_y[k]  <= Y_MAX;
                        blob_dy[k] <= 1'b0;
                    end else
                        blob_y[k] <= blob_y[k] + STEP_W;
                end else if (blob_y[k] < STEP_W) begin
                    blob_y[k]  <= '0;
                    blob_dy[k] <= 1'b1;
                end else
                    blob_y[k] <= blob_y[k] - STEP_W;
            end
        end
    end

    // Registered outputs, one pclk behind the counter state that produces them.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            cam.href    <= 1'b0;
            cam.hsync   <= 1'b1;
            cam.vsync   <= 1'b1;
            cam.camData <= 8'h00;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else if (state == RUN) begin
            cam.href    <= active;
            cam.hsync   <= !(px >= HS_START && px < HS_END);
            cam.vsync   <= !(cy >= VS_START && cy < VS_END);
            cam.camData <= active ? pix : 8'h00;
            frame_done  <= frame_end;
            if (frame_end)
                frame_count <= frame_count + 16'd1;
        end else begin
            cam.href    <= 1'b0;
            cam.hsync   <= 1'b1;
            cam.vsync   <= 1'b1;
            cam.camData <= 8'h00;
            frame_done  <= 1'b0;
        end
    end
endmodule

// File: doc/camera_fake_pattern_gen.md
Name: camera_fake_pattern_gen

Overview:
- Parametrised successor to the static fake camera: emits OV-style timing (pclk, href, hsync, vsync, 8-bit data) for a configurable resolution.
- Pattern is selectable at runtime: black, square grid, x-ramp or N moving bouncing blobs.
- Sits in place of the sensor front-end so the blob-detection/mocap pipeline can be exercised with moving, known targets.
- Adds frame-synchronous enable/mode switching and a frame counter.

Parameters:
- PCLK_PER_PIXEL, 1, pclk cycles per pixel (each pixel value held this long)
- WIDTH, 1280, active pixels per line
- H_FRONT_PORCH, 19, pixels after active region
- H_SYNC_PULSE, 80, hsync low width in pixels
- H_BACK_PORCH, 45, pixels after sync
- HEIGHT, 800, active lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 3, vsync low width in lines
- V_BACK_PORCH, 17, lines
- NUM_BLOBS, 4, moving blobs in mode 3 (1..4)
- BLOB_SIZE, 60, blob edge length in pixels/lines
- STEP, 4, blob displacement per frame in x and y
- GRID_PITCH, 120, square grid pitch (mode 1); squares are GRID_PITCH/2 wide

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- en  in  1  generator enable, sampled at frame boundary
- mode  in  2  0 black, 1 grid, 2 x-ramp, 3 blobs; sampled at frame boundary
- href  out  1  high during active pixels
- hsync  out  1  active low
- vsync  out  1  active low
- camData  out  8  pixel data
- frame_done  out  1  one-cycle pulse on last pclk of each frame
- frame_count  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset: reset, asynchronous, active-high; clock pclk. All counters 0, blobs at start positions, en/mode latches 0. Outputs: href 0, hsync 1, vsync 1, camData 0, frame_done 0, frame_count 0.
- LINE_TOTAL = (WIDTH+HFP+HS+HBP)*PCLK_PER_PIXEL; FRAME_LINES = HEIGHT+VFP+VS+VBP.
- cx counts 0..LINE_TOTAL-1. cy counts 0..FRAME_LINES-1, advancing when cx wraps. No extra cycle at the maximum.
- px = cx / PCLK_PER_PIXEL, computed with a sub-pixel counter, no divider.
- Frame boundary: cx==LINE_TOTAL-1 and cy==FRAME_LINES-1. frame_done pulses high and frame_count increments there.
- States: IDLE, RUN.
  - IDLE: counters held at 0, outputs at reset idle values. en sampled every cycle; en=1 -> RUN next cycle with cx=cy=0 and mode latched.
  - RUN: en and mode sampled only at the frame boundary.
    - en=0 -> IDLE after boundary.
    - en=1 -> next frame with new mode.
    - Mid-frame en/mode changes are ignored.
- Combinational decode:
  - href = cy<HEIGHT && cx<WIDTH*PPP.
  - hsync low for px in [WIDTH+HFP, WIDTH+HFP+HS).
  - vsync low for cy in [HEIGHT+VFP, HEIGHT+VFP+VS), all cx.
- Pixel value per mode:
  - 0: 0x00.
  - 1: 0xFF when (px mod GRID_PITCH) < GRID_PITCH/2 and (cy mod GRID_PITCH) < GRID_PITCH/2, using running modulo counters, else 0x00.
  - 2: px[7:0].
  - 3: 0xFF when inside any blob, else 0x00.
- Data is forced to 0x00 whenever href=0.
- Latency: all outputs registered, exactly 1 pclk after the counter state that produces them.
- Blobs:
  - Blob k starts at x=k*(WIDTH/NUM_BLOBS), y=k*BLOB_SIZE mod (HEIGHT-BLOB_SIZE).
  - Initial direction: dx=+1, dy=+1 for even k; dx=-1, dy=+1 for odd k.
  - Inside test: px in [x, x+BLOB_SIZE) and cy in [y, y+BLOB_SIZE).
  - Positions update only at the frame boundary and only in RUN with latched mode 3.
  - Bounce: if x+STEP > WIDTH-BLOB_SIZE while moving +, set x=WIDTH-BLOB_SIZE and reverse. If x < STEP while moving -, set x=0 and reverse. Same rule for y against HEIGHT.
  - Positions are retained across mode changes and IDLE. They are reset only by reset.
- Reset mid-frame: immediate return to reset state; the frame is aborted and not counted.

Optional Feature:
- CAMFAKE_NOISE_EN
- Defined: a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset) advances every pclk in RUN. In active region, background pixels (value 0x00) output lfsr[3:0], i.e. low-level noise. 0xFF pixels are unchanged.
- Undefined: no LFSR; background is exactly 0x00.

Test Plan:
- Bench params: WIDTH=16, HFP=HS=HBP=2, HEIGHT=8, VFP=VS=VBP=1, PPP=1.
  - LINE_TOTAL=22, FRAME_LINES=11, frame length 242 pclk.
- Timing, en=1 mode 2: per line, href high 16 cycles with camData 0,1..15 one cycle after counter; hsync low cycles 18-19. vsync low for line 9 (all 22 cycles). frame_done every 242 cycles; frame_count 1,2,3.
- PPP=2, mode 2: each data value held 2 cycles; href high 32 of 44 cycles per line.
- Mode switch: mode changed 1->3 at cycle 50 of frame 1 -> frame 1 stays grid, frame 2 shows blobs. en dropped mid-frame -> frame completes, frame_done pulses, then outputs idle (href 0, hsync 1, vsync 1).
- Blob bounce, NUM_BLOBS=1, BLOB_SIZE=4, STEP=4, start (0,0):
  - x sequence over frames 0,4,8,12,12,8.
  - y sequence over frames 0,4,4,0.
  - Verify 0xFF window each frame.
- Async reset at cy=3: outputs idle next edge, frame_count 0, blob back to start. After release with en=1, first frame starts at cx=cy=0.
- With CAMFAKE_NOISE_EN: mode 0 active pixels match reference LFSR[3:0] sequence from seed 0xACE1. Without it: all 0x00.
